// File: rtl/serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_ctrl
// Brief    : Bit-serial controller driving an external 1-bit ALU slice, LSB first.
// Revision : 1.0
// ============================================================================
module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cb_flag,
    output logic             zero_flag,
    output logic             slice_in1,
    output logic             slice_in2,
    output logic             slice_cb_in,
    output logic [2:0]       slice_code_op,
    input  logic             slice_result,
    input  logic             slice_cb_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_cb;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_result;
    logic             r_cb_flag;
    logic             r_zero;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_run;

    assign w_run       = (r_state == c_RUN);
    assign w_shift_nxt = {slice_result, r_shift[WIDTH-1:1]};

    // Slice is only driven while an operation is actually shifting.
    assign slice_in1     = w_run ? r_a[0] : 1'b0;
    assign slice_in2     = w_run ? r_b[0] : 1'b0;
    assign slice_cb_in   = w_run ? r_cb   : 1'b0;
    assign slice_code_op = w_run ? r_op   : 3'b000;

    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign result    = r_result;
    assign cb_flag   = r_cb_flag;
    assign zero_flag = r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= 3'b000;
            r_cb      <= 1'b0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_result  <= '0;
            r_cb_flag <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_op      <= op;
                        r_cb      <= cin;
                        r_cnt     <= '0;
                        r_shift   <= '0;
                        r_result  <= '0;
                        r_cb_flag <= 1'b0;
                        r_zero    <= 1'b0;
                        r_state   <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_shift <= w_shift_nxt;
                    r_cb    <= slice_cb_out;
                    r_cnt   <= r_cnt + CW'(1);
                    // Published outputs only change on the final bit, so they hold stable otherwise.
                    if (r_cnt == c_LAST) begin
                        r_result  <= w_shift_nxt;
                        r_cb_flag <= slice_cb_out;
                        r_zero    <= (w_shift_nxt == '0);
                        r_state   <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_alu_ctrl
// Brief    : Scoreboard bench for serial_alu_ctrl with an add/subtract slice model.
// Revision : 1.0
// ============================================================================
module tb_serial_alu_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cb_flag, zero_flag;
    logic [W-1:0] result;
    logic         slice_in1, slice_in2, slice_cb_in;
    logic [2:0]   slice_code_op;
    logic         slice_result, slice_cb_out;

    typedef struct {
        logic [W-1:0] res;
        logic         cb;
        logic         zero;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cb_flag(cb_flag),
        .zero_flag(zero_flag), .slice_in1(slice_in1), .slice_in2(slice_in2),
        .slice_cb_in(slice_cb_in), .slice_code_op(slice_code_op),
        .slice_result(slice_result), .slice_cb_out(slice_cb_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 1-bit slice: 000 full add, 001 subtract with borrow.
    always_comb begin
        slice_result = 1'b0;
        slice_cb_out = 1'b0;
        case (slice_code_op)
            3'b000: begin
                slice_result = slice_in1 ^ slice_in2 ^ slice_cb_in;
                slice_cb_out = (slice_in1 & slice_in2) | (slice_in1 & slice_cb_in) | (slice_in2 & slice_cb_in);
            end
            3'b001: begin
                slice_result = slice_in1 ^ slice_in2 ^ slice_cb_in;
                slice_cb_out = (~slice_in1 & slice_in2) | (~(slice_in1 ^ slice_in2) & slice_cb_in);
            end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("cb_flag", 32'(cb_flag), 32'(e.cb));
                check("zero_flag", 32'(zero_flag), 32'(e.zero));
                check("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the first RUN cycle.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic ci, input logic [W-1:0] er, input logic ecb, input bit expect_done);
        exp_t e;
        op = o; a = xa; b = xb; cin = ci; start = 1'b1;
        if (expect_done) begin
            e.res = er; e.cb = ecb; e.zero = (er == '0); e.cyc = cyc + 1 + W;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && (q.size() != 0 || busy); i++) @(negedge clk);
        check(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ctrl", {busy, done, cb_flag, zero_flag}, 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_slice", {slice_in1, slice_in2, slice_cb_in, slice_code_op}, 32'd0);

        // add 35+0F
        issue(3'b000, 8'h35, 8'h0F, 1'b0, 8'h44, 1'b0, 1'b1);
        check("run_slice_drive", {slice_in1, slice_in2, slice_cb_in, slice_code_op}, 32'b110000);
        check("run_busy", 32'(busy), 32'd1);
        check("run_result_cleared", 32'(result), 32'd0);
        drain("drain_add1");
        repeat (3) @(negedge clk);
        check("hold_result", 32'(result), 32'h44);
        check("idle_busy", 32'(busy), 32'd0);

        issue(3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
        drain("drain_add2");
        @(negedge clk);
        check("hold_zero", 32'(zero_flag), 32'd1);

        issue(3'b001, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b1);
        drain("drain_sub1");
        issue(3'b001, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b1);
        drain("drain_sub2");

        // start pulse and operand change mid-run must be ignored
        issue(3'b000, 8'h35, 8'h0F, 1'b0, 8'h44, 1'b0, 1'b1);
        for (int i = 1; i <= W + 1; i++) begin
            check("busy_continuous", 32'(busy), 32'd1);
            if (i == 3) begin
                start = 1'b1; a = 8'hAA;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_after_done", 32'(busy), 32'd0);
        drain("drain_ignore");

        // reset mid-run aborts without done
        issue(3'b000, 8'h11, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ctrl", {busy, done, cb_flag, zero_flag}, 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_slice", {slice_in1, slice_in2, slice_cb_in, slice_code_op}, 32'd0);
        repeat (W + 4) @(negedge clk);
        issue(3'b000, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1);
        drain("drain_post_reset");

        // start held high: three accepts, spaced W+2 cycles apart
        begin
            exp_t e;
            int c0;
            c0 = cyc;
            op = 3'b000; a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
            for (int n = 0; n < 3; n++) begin
                e.res = 8'h07; e.cb = 1'b0; e.zero = 1'b0; e.cyc = c0 + 1 + W + n * (W + 2);
                q.push_back(e);
            end
            repeat (2 * (W + 2) + 1) @(negedge clk);
            start = 1'b0;
        end
        drain("drain_b2b");
        repeat (4) @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
